i2c_arbiter: RTL and testbench
==============================

I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one I2C master (range 1..8).
REQ-002 SHALL have parameter TIMEOUT, default 4096, meaning the maximum clk cycles allowed in START or WAIT before the transaction is aborted.
REQ-003 clk  in  1  system clock; all logic rising-edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 req  in  NUM_REQ  per-requester transaction request, level.
REQ-006 req_addr  in  7*NUM_REQ  7-bit slave address, requester i at bits [7i+6:7i].
REQ-007 req_wdata  in  8*NUM_REQ  write byte, requester i at [8i+7:8i].
REQ-008 req_rw  in  NUM_REQ  direction per requester, passed unchanged to m_rw.
REQ-009 gnt  out  NUM_REQ  one-hot grant, held from selection through DONE.
REQ-010 done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-011 err  out  1  one-cycle pulse coincident with done when the transaction timed out.
REQ-012 rdata  out  8  byte read from m_rdata; valid in the cycle done pulses.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 m_enable / m_addr[7] / m_wdata[8] / m_rw  out  drive the master's enable, addr, data_write_master, rw.
REQ-015 m_ready  in  1  master ready (high = idle); m_rdata  in  8  master data_read_master.

Function
REQ-016 SHALL implement FSM states IDLE, START, WAIT, DONE.
REQ-017 IDLE: when m_ready=1 and req!=0, SHALL select a winner by round-robin, register gnt, latch its addr/wdata/rw into m_addr/m_wdata/m_rw, go to START.
REQ-018 Round-robin SHALL give highest priority to index (last_winner+1) mod NUM_REQ, wrapping N-1 -> 0; last_winner resets to NUM_REQ-1, so requester 0 wins first.
REQ-019 IDLE with m_ready=0 SHALL grant nothing and stay in IDLE.
REQ-020 START: m_enable SHALL be 1; on m_ready=0 go to WAIT with m_enable=0 in the next cycle.
REQ-021 WAIT: m_enable SHALL be 0; on m_ready=1 capture m_rdata into rdata and go to DONE.
REQ-022 Timeout counter SHALL clear on entry to START and WAIT; reaching TIMEOUT in either SHALL force m_enable=0, set err, go to DONE; rdata SHALL then hold its previous value.
REQ-023 DONE (exactly one cycle): done[winner]=1, err as set, last_winner updated; next cycle gnt=0, state IDLE.
REQ-024 Latency: req sampled in IDLE at edge k -> gnt and m_* valid after edge k, m_enable high after edge k+1.
REQ-025 m_addr/m_wdata/m_rw SHALL stay stable from latch until DONE regardless of requester input changes.
REQ-026 Requester deasserting req after grant SHALL NOT abort; transaction completes and done still pulses.
REQ-027 Requester holding req continuously SHALL NOT win consecutively while another req bit is set.
REQ-028 With NUM_REQ=1 the block SHALL degenerate to a single-requester sequencer with identical timing.

Reset
REQ-029 On rst=0 SHALL asynchronously enter IDLE: gnt=0, done=0, err=0, rdata=0, busy=0, m_enable=0, m_addr=0, m_wdata=0, m_rw=0, counter=0, last_winner=NUM_REQ-1.
REQ-030 Reset mid-transaction SHALL drop m_enable within the same asynchronous assertion and emit no done pulse.

Structure
REQ-031 FSM state encodings and the default TIMEOUT SHALL live in the shared I2C defines header used by master and slave.
REQ-032 Round-robin selection (req, last_winner -> one-hot winner, index) SHALL be one sub-module, rr_select, purely combinational.

Verification
REQ-033 Single req[0], addr 7'b1010101, wdata 8'hAE, rw=0; master model drops ready 2 cycles after enable, raises 20 later -> m_addr=55h, m_wdata=AEh, done[0] one pulse, err=0.
REQ-034 req=4'b1111 held continuously -> grant order 0,1,2,3,0 with one DONE cycle between.
REQ-035 Read on req[2], rw=1, master returns m_rdata=8'hAB -> rdata=ABh exactly in done[2] cycle.
REQ-036 Master never drops ready after enable, TIMEOUT=16 -> m_enable low after 16 START cycles, err and done[0] pulse together, rdata unchanged.
REQ-037 rst asserted while in WAIT -> m_enable=0, gnt=0, no done; after release req[1] alone is granted normally.
REQ-038 req[3] withdrawn one cycle after grant and m_ready held 0 in IDLE beforehand -> no grant while m_ready=0; granted transaction completes with done[3].

Source files
------------

// File: rtl/i2c_arbiter_pkg.sv
// Shared I2C definitions: arbiter FSM encoding and the default transaction timeout.
package i2c_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } arb_state_e;

  localparam int unsigned DefaultTimeout = 4096;

endpackage

// File: rtl/i2c_arbiter_if.sv
// Link between the arbiter (master modport) and the shared I2C master core (slave modport).
interface i2c_arbiter_if;

  logic       m_enable;
  logic [6:0] m_addr;
  logic [7:0] m_wdata;
  logic       m_rw;
  logic       m_ready;
  logic [7:0] m_rdata;

  modport master (
    output m_enable, m_addr, m_wdata, m_rw,
    input  m_ready, m_rdata
  );

  modport slave (
    input  m_enable, m_addr, m_wdata, m_rw,
    output m_ready, m_rdata
  );

endinterface

// File: rtl/i2c_arbiter_rr_select.sv
// Combinational round-robin pick: first set request after last_winner, wrapping N-1 -> 0.
module rr_select #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdxW    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    last,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IdxW-1:0]    idx,
  output logic               valid
);

  int unsigned cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last) + k) % NUM_REQ;
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master among NUM_REQ requesters, with a START/WAIT
// timeout that aborts a stalled transaction and flags err alongside done.
module i2c_arbiter
  import i2c_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]   req_rw,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic [7:0]           rdata,
  output logic                 busy,
  i2c_arbiter_if.master        bus
);

  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW   = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [IdxW-1:0]     idx_q, idx_d, last_q, last_d;
  logic [6:0]          addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d, rdata_q, rdata_d;
  logic                rw_q, rw_d, en_q, en_d, err_q, err_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic [NUM_REQ-1:0]  sel_onehot;
  logic [IdxW-1:0]     sel_idx;
  logic                sel_valid;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_rr_select (
    .req    (req),
    .last   (last_q),
    .onehot (sel_onehot),
    .idx    (sel_idx),
    .valid  (sel_valid)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    en_d    = en_q;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.m_ready && sel_valid) begin
          gnt_d   = sel_onehot;
          idx_d   = sel_idx;
          addr_d  = req_addr[7*32'(sel_idx) +: 7];
          wdata_d = req_wdata[8*32'(sel_idx) +: 8];
          rw_d    = req_rw[sel_idx];
          en_d    = 1'b0;
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == CntMax) begin
          en_d    = 1'b0;
          err_d   = 1'b1;
          state_d = StDone;
        end else if (en_q && !bus.m_ready) begin
          // Only an acknowledged enable counts as the master accepting the transfer.
          en_d    = 1'b0;
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          en_d  = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWait: begin
        if (bus.m_ready) begin
          rdata_d = bus.m_rdata;
          state_d = StDone;
        end else if (cnt_q == CntMax) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        gnt_d   = '0;
        last_d  = idx_q;
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= IdxW'(NUM_REQ - 1);
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      en_q    <= en_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt          = gnt_q;
  assign done         = (state_q == StDone) ? gnt_q : '0;
  assign err          = err_q;
  assign rdata        = rdata_q;
  assign busy         = (state_q != StIdle);
  assign bus.m_enable = en_q;
  assign bus.m_addr   = addr_q;
  assign bus.m_wdata  = wdata_q;
  assign bus.m_rw     = rw_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Bench for i2c_arbiter: grant-order table, directed corner sequences, and randomized
// transactions checked against a transaction-level round-robin model.
module tb_i2c_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [27:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_rw;
  logic [3:0]  gnt, done;
  logic        err, busy;
  logic [7:0]  rdata;

  logic [3:0]  req_to;
  logic [3:0]  gnt_to, done_to;
  logic        err_to, busy_to;
  logic [7:0]  rdata_to;

  i2c_arbiter_if bus ();
  i2c_arbiter_if bus_to ();

  i2c_arbiter #(.NUM_REQ(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rw(req_rw), .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy), .bus(bus)
  );

  i2c_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut_to (
    .clk(clk), .rst(rst), .req(req_to), .req_addr(28'h0), .req_wdata(32'h0),
    .req_rw(4'h0), .gnt(gnt_to), .done(done_to), .err(err_to), .rdata(rdata_to),
    .busy(busy_to), .bus(bus_to)
  );

  always #5 clk = ~clk;

  // The timeout instance sees a master that never accepts the enable.
  assign bus_to.m_ready = 1'b1;
  assign bus_to.m_rdata = 8'h5A;

  // Master model: drops ready mm_dly cycles after seeing enable, raises it mm_blen later.
  logic       mm_ready = 1'b1;
  logic       mm_force_low = 1'b0;
  int         mm_phase = 0, mm_cnt = 0, mm_dly = 2, mm_blen = 5;
  logic [7:0] mm_rd = 8'h00;

  assign bus.m_ready = mm_force_low ? 1'b0 : mm_ready;

  initial begin
    bus.m_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mm_ready = 1'b1; mm_phase = 0; mm_cnt = 0;
      end else if (mm_phase == 0) begin
        if (bus.m_enable && bus.m_ready) begin
          mm_cnt++;
          if (mm_cnt >= mm_dly) begin mm_ready = 1'b0; mm_phase = 1; mm_cnt = 0; end
        end else mm_cnt = 0;
      end else begin
        mm_cnt++;
        if (mm_cnt >= mm_blen) begin
          mm_ready = 1'b1; bus.m_rdata = mm_rd; mm_phase = 0; mm_cnt = 0;
        end
      end
    end
  end

  int n_checks = 0, n_fail = 0;
  int last_w = 3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rr_expect(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic scramble();
    req = 4'($urandom); req_addr = 28'($urandom); req_wdata = $urandom; req_rw = 4'($urandom);
  endtask

  // One transaction from IDLE. mode 0: hold inputs, 1: scramble every cycle, 2: withdraw req.
  task automatic do_txn(input logic [3:0] r, input int exp_w, input int mode, input int dly,
                        input int blen, input logic [7:0] mrd, input bit fix,
                        input logic [6:0] fa, input logic [7:0] fw, input logic fr,
                        input string tag);
    logic [6:0] ea; logic [7:0] ew; logic er; logic [3:0] eg; int waited;
    for (int i = 0; i < 4; i++) begin
      req_addr[7*i +: 7] = 7'($urandom);
      req_wdata[8*i +: 8] = 8'($urandom);
      req_rw[i] = 1'($urandom);
    end
    if (fix) begin
      req_addr[7*exp_w +: 7] = fa; req_wdata[8*exp_w +: 8] = fw; req_rw[exp_w] = fr;
    end
    ea = req_addr[7*exp_w +: 7]; ew = req_wdata[8*exp_w +: 8]; er = req_rw[exp_w];
    eg = 4'(1 << exp_w);
    mm_dly = dly; mm_blen = blen; mm_rd = mrd; req = r;
    @(negedge clk);
    chk({tag, "_gnt"}, gnt, eg);
    chk({tag, "_addr"}, bus.m_addr, ea);
    chk({tag, "_wdata"}, bus.m_wdata, ew);
    chk({tag, "_rw"}, bus.m_rw, er);
    chk({tag, "_busy"}, busy, 1);
    if (mode == 1) scramble();
    if (mode == 2) req = 4'h0;
    @(negedge clk);
    chk({tag, "_en"}, bus.m_enable, 1);
    waited = 0;
    while (done == 4'h0 && waited < 300) begin
      if (mode == 1) scramble();
      @(negedge clk);
      waited++;
    end
    chk({tag, "_done"}, done, eg);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rdata"}, rdata, mrd);
    chk({tag, "_addr_hold"}, {bus.m_rw, bus.m_wdata, bus.m_addr}, {er, ew, ea});
    chk({tag, "_en_done"}, bus.m_enable, 0);
    @(negedge clk);
    chk({tag, "_post"}, {done, gnt, busy}, 9'h0);
    last_w = exp_w;
  endtask

  typedef struct {
    logic [3:0] req;
    int         winner;
    logic [7:0] mrd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int j, en_cnt, found;
    tbl[0]  = '{4'b1111, 0, 8'h11};  tbl[1]  = '{4'b1111, 1, 8'h22};
    tbl[2]  = '{4'b1111, 2, 8'h33};  tbl[3]  = '{4'b1111, 3, 8'h44};
    tbl[4]  = '{4'b1111, 0, 8'h55};  tbl[5]  = '{4'b1010, 1, 8'h66};
    tbl[6]  = '{4'b1010, 3, 8'h77};  tbl[7]  = '{4'b0101, 0, 8'h88};
    tbl[8]  = '{4'b1000, 3, 8'h99};  tbl[9]  = '{4'b0110, 1, 8'hA5};
    tbl[10] = '{4'b0010, 1, 8'h5C};  tbl[11] = '{4'b1001, 3, 8'hC3};

    rst = 1'b1; req = 4'h0; req_addr = '0; req_wdata = '0; req_rw = '0; req_to = 4'h0;
    #1 rst = 1'b0;
    #2;
    chk("rst_outs", {gnt, done, err, rdata, busy}, 18'h0);
    chk("rst_bus", {bus.m_enable, bus.m_addr, bus.m_wdata, bus.m_rw}, 17'h0);
    chk("rst_to", {gnt_to, done_to, err_to, rdata_to, bus_to.m_enable}, 18'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      do_txn(tbl[i].req, tbl[i].winner, 0, 1 + (i % 3), 2 + i, tbl[i].mrd, 1'b0, 7'h0, 8'h0,
             1'b0, $sformatf("tbl%0d", i));

    do_txn(4'b0001, 0, 0, 2, 20, 8'h3C, 1'b1, 7'b1010101, 8'hAE, 1'b0, "wr0");
    chk("wr0_addr55", 7'b1010101, 7'h55);
    do_txn(4'b0100, 2, 0, 1, 6, 8'hAB, 1'b1, 7'h2A, 8'h00, 1'b1, "rd2");

    for (int t = 0; t < 30; t++) begin
      logic [3:0] r;
      r = 4'($urandom_range(1, 15));
      do_txn(r, rr_expect(r, last_w), $urandom_range(0, 2), $urandom_range(1, 4),
             $urandom_range(1, 12), 8'($urandom), 1'b0, 7'h0, 8'h0, 1'b0,
             $sformatf("rnd%0d", t));
    end

    // Reset while the master is busy.
    mm_dly = 1; mm_blen = 30; req = 4'b0010;
    j = 0;
    while (mm_phase != 1 && j < 20) begin @(negedge clk); j++; end
    chk("rstw_reached", mm_phase, 1);
    @(negedge clk);
    chk("rstw_wait", {gnt, busy, bus.m_enable}, {4'b0010, 1'b1, 1'b0});
    #2 rst = 1'b0;
    #1 chk("rstw_async", {gnt, busy, bus.m_enable, done}, 10'h0);
    repeat (2) begin @(negedge clk); chk("rstw_nodone", done, 0); end
    req = 4'h0; rst = 1'b1; last_w = 3;
    do_txn(4'b0010, 1, 0, 2, 4, 8'h7E, 1'b0, 7'h0, 8'h0, 1'b0, "after_rst");

    // Master busy in IDLE: nothing may be granted.
    mm_force_low = 1'b1; req = 4'b1000;
    repeat (5) begin @(negedge clk); chk("nrdy_nognt", {gnt, busy}, 5'h0); end
    mm_force_low = 1'b0;
    do_txn(4'b1000, 3, 2, 3, 5, 8'h19, 1'b0, 7'h0, 8'h0, 1'b0, "withdraw3");

    // Timeout instance: enable must fall after 16 START cycles with err and done together.
    req_to = 4'b0001;
    @(negedge clk);
    chk("to_gnt", {gnt_to, bus_to.m_enable}, {4'b0001, 1'b0});
    req_to = 4'h0;
    en_cnt = 0; found = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done_to != 4'h0) begin found = k; break; end
      if (bus_to.m_enable) en_cnt++;
    end
    chk("to_cycle", found, 16);
    chk("to_en_cycles", en_cnt, 15);
    chk("to_done_err", {done_to, err_to, bus_to.m_enable}, {4'b0001, 1'b1, 1'b0});
    chk("to_rdata", rdata_to, 8'h00);
    @(negedge clk);
    chk("to_post", {done_to, err_to, gnt_to, busy_to}, 10'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
